lcd_controller: RTL and testbench

LCD_CONTROLLER -- requirements
Module: lcd_controller

---
 rtl/lcd_controller.sv | 213 +++++++++++++++++++++
 tb/tb_lcd_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
`default_nettype none
// ============================================================================
// Module : lcd_controller
// Desc   : FIFO-buffered write controller for an HD44780-style LCD, 8/4-bit bus.
// Rev    : 1.0  initial release
// ============================================================================
module lcd_controller #(
    parameter int FIFO_DEPTH    = 8,
    parameter int BUS_4BIT      = 0,
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 80000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs,
    input  logic [7:0] wdata,
    input  logic       wenable,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] lcd_data,
    output logic [1:0] lcd_ctrl,
    output logic       lcd_enable
);

    localparam int c_aw   = $clog2(FIFO_DEPTH);
    localparam int c_cntw = c_aw + 1;
    localparam int c_cw   = $clog2(LONG_EXEC_CYC + 1);

    localparam logic [c_cntw-1:0] c_cnt_full = c_cntw'(FIFO_DEPTH);
    localparam logic [c_cntw-1:0] c_cnt_one  = c_cntw'(1);
    localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);
    localparam logic [c_cw-1:0]   c_tmr_one  = c_cw'(1);
    localparam logic [c_cw-1:0]   c_setup_ld = c_cw'(SETUP_CYC - 1);
    localparam logic [c_cw-1:0]   c_pulse_ld = c_cw'(PULSE_CYC - 1);
    localparam logic [c_cw-1:0]   c_hold_ld  = c_cw'(HOLD_CYC - 1);
    localparam logic [c_cw-1:0]   c_exec_ld  = c_cw'(EXEC_CYC - 1);
    localparam logic [c_cw-1:0]   c_long_ld  = c_cw'(LONG_EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_cw-1:0]   r_tmr;
    logic [c_cw-1:0]   w_tmr_nxt;
    logic              w_tmr_zero;

    logic [8:0]        r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cntw-1:0] r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [8:0]        w_head;

    logic              w_ld_hi;
    logic              w_ld_lo;
    logic              w_en_nxt;
    logic              w_is_long;
    logic [7:0]        r_byte;
    logic              r_rs;
    logic              r_lo_phase;
    logic [7:0]        r_lcd_data;
    logic [1:0]        r_lcd_ctrl;
    logic              r_lcd_enable;
    logic              r_overflow;

    assign w_full     = (r_count == c_cnt_full);
    assign w_empty    = (r_count == '0);
    assign w_push     = wenable & ~w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_tmr_zero = (r_tmr == '0);
    // Clear display and return home need the long execution time.
    assign w_is_long  = ~r_rs & ((r_byte == 8'h01) | (r_byte == 8'h02) | (r_byte == 8'h03));

    assign full       = w_full;
    assign busy       = ~w_empty | (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign lcd_data   = r_lcd_data;
    assign lcd_ctrl   = r_lcd_ctrl;
    assign lcd_enable = r_lcd_enable;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_en_nxt    = 1'b0;
        w_pop       = 1'b0;
        w_ld_hi     = 1'b0;
        w_ld_lo     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_ld_hi     = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_tmr_nxt   = c_setup_ld;
                end
            end
            S_SETUP: begin
                if (w_tmr_zero) begin
                    w_state_nxt = S_PULSE;
                    w_tmr_nxt   = c_pulse_ld;
                    w_en_nxt    = 1'b1;
                end else begin
                    w_tmr_nxt   = r_tmr - c_tmr_one;
                end
            end
            S_PULSE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = S_HOLD;
                    w_tmr_nxt   = c_hold_ld;
                end else begin
                    w_tmr_nxt   = r_tmr - c_tmr_one;
                    w_en_nxt    = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_tmr_zero) begin
                    // In nibble mode the first HOLD hands over to the low nibble.
                    if ((BUS_4BIT != 0) && !r_lo_phase) begin
                        w_ld_lo     = 1'b1;
                        w_state_nxt = S_SETUP;
                        w_tmr_nxt   = c_setup_ld;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_tmr_nxt   = w_is_long ? c_long_ld : c_exec_ld;
                    end
                end else begin
                    w_tmr_nxt   = r_tmr - c_tmr_one;
                end
            end
            S_WAIT: begin
                if (w_tmr_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmr_nxt   = r_tmr - c_tmr_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {rs, wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_byte       <= 8'h00;
            r_rs         <= 1'b0;
            r_lo_phase   <= 1'b0;
            r_lcd_data   <= 8'h00;
            r_lcd_ctrl   <= 2'b00;
            r_lcd_enable <= 1'b0;
        end else begin
            r_overflow   <= wenable & w_full;
            r_lcd_enable <= w_en_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_ld_hi) begin
                r_byte     <= w_head[7:0];
                r_rs       <= w_head[8];
                r_lo_phase <= 1'b0;
                r_lcd_ctrl <= {w_head[8], 1'b0};
                r_lcd_data <= (BUS_4BIT != 0) ? {w_head[7:4], 4'h0} : w_head[7:0];
            end else if (w_ld_lo) begin
                r_lo_phase <= 1'b1;
                r_lcd_data <= {r_byte[3:0], 4'h0};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_controller
// Desc   : Directed, table-driven bench for lcd_controller (8-bit and 4-bit).
// Rev    : 1.0  initial release
// ============================================================================
module tb_lcd_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rs;
    logic [7:0] wdata;
    logic       wen8;
    logic       wen4;

    logic       full8, busy8, ovf8, e8;
    logic [7:0] d8;
    logic [1:0] c8;
    logic       full4, busy4, ovf4, e4;
    logic [7:0] d4;
    logic [1:0] c4;

    always #5 clk = ~clk;

    lcd_controller #(
        .FIFO_DEPTH(4), .BUS_4BIT(0), .SETUP_CYC(2), .PULSE_CYC(3),
        .HOLD_CYC(2), .EXEC_CYC(5), .LONG_EXEC_CYC(20)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .rs(rs), .wdata(wdata), .wenable(wen8),
        .full(full8), .busy(busy8), .overflow(ovf8),
        .lcd_data(d8), .lcd_ctrl(c8), .lcd_enable(e8)
    );

    lcd_controller #(
        .FIFO_DEPTH(4), .BUS_4BIT(1), .SETUP_CYC(2), .PULSE_CYC(3),
        .HOLD_CYC(2), .EXEC_CYC(5), .LONG_EXEC_CYC(20)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .rs(rs), .wdata(wdata), .wenable(wen4),
        .full(full4), .busy(busy4), .overflow(ovf4),
        .lcd_data(d4), .lcd_ctrl(c4), .lcd_enable(e4)
    );

    logic       cur_sel = 1'b0;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic       m_busy;
    assign m_data = cur_sel ? d4 : d8;
    assign m_ctrl = cur_sel ? c4 : c8;
    assign m_busy = cur_sel ? busy4 : busy8;

    int n_chk = 0;
    int n_err = 0;

    // Edge counter and enable-pulse recorders (rise edge, data at rise, width).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         r8_cyc[$];
    logic [7:0] r8_dat[$];
    int         l8[$];
    int         len8 = 0;
    logic       p8 = 1'b0;
    int         r4_cyc[$];
    logic [7:0] r4_dat[$];
    int         l4[$];
    int         len4 = 0;
    logic       p4 = 1'b0;

    always @(negedge clk) begin
        if (e8 && !p8) begin r8_cyc.push_back(cyc); r8_dat.push_back(d8); len8 = 0; end
        if (e8) len8++;
        if (!e8 && p8) l8.push_back(len8);
        p8 = e8;
        if (e4 && !p4) begin r4_cyc.push_back(cyc); r4_dat.push_back(d4); len4 = 0; end
        if (e4) len4++;
        if (!e4 && p4) l4.push_back(len4);
        p4 = e4;
    end

    task automatic clear_mon();
        r8_cyc.delete(); r8_dat.delete(); l8.delete();
        r4_cyc.delete(); r4_dat.delete(); l4.delete();
    endtask

    task automatic check(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
        end
    endtask

    typedef struct {
        logic       sel;
        logic       rs;
        logic [7:0] wdata;
        logic [7:0] exp_hi;
        logic [7:0] exp_lo;
        int         exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int         t0;
        int         bl;
        int         nexp;
        logic [7:0] d1;
        logic [1:0] c1;
        logic [7:0] dend;
        int         rc[$];
        logic [7:0] rd[$];
        int         rl[$];
        d1 = 8'h00; c1 = 2'b00; dend = 8'h00; bl = -1;
        cur_sel = v.sel;
        clear_mon();
        rs = v.rs;
        wdata = v.wdata;
        if (v.sel) wen4 = 1'b1; else wen8 = 1'b1;
        @(posedge clk); #1;
        wen4 = 1'b0; wen8 = 1'b0;
        t0 = cyc;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin d1 = m_data; c1 = m_ctrl; end
            if (!m_busy) begin bl = k; dend = m_data; break; end
        end
        check($sformatf("v%0d_data_edge1", idx), int'(d1), int'(v.exp_hi));
        check($sformatf("v%0d_ctrl_edge1", idx), int'(c1), int'({v.rs, 1'b0}));
        check($sformatf("v%0d_busy_low", idx), bl, v.exp_busy);
        check($sformatf("v%0d_data_held", idx), int'(dend), int'(v.sel ? v.exp_lo : v.exp_hi));
        if (v.sel) begin rc = r4_cyc; rd = r4_dat; rl = l4; end
        else       begin rc = r8_cyc; rd = r8_dat; rl = l8; end
        nexp = v.sel ? 2 : 1;
        check($sformatf("v%0d_npulse", idx), rc.size(), nexp);
        for (int p = 0; p < nexp; p++) begin
            if (p < rc.size()) begin
                check($sformatf("v%0d_rise%0d_edge", idx, p), rc[p] - t0, (p == 0) ? 3 : 10);
                check($sformatf("v%0d_rise%0d_data", idx, p), int'(rd[p]),
                      int'((p == 0) ? v.exp_hi : v.exp_lo));
            end
            if (p < rl.size()) begin
                check($sformatf("v%0d_pulse%0d_len", idx, p), rl[p], 3);
            end
        end
    endtask

    task automatic test_overflow();
        int t0;
        int bl;
        t0 = 0; bl = -1;
        cur_sel = 1'b0;
        clear_mon();
        rs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wdata = 8'(8'h30 + i);
            wen8 = 1'b1;
            @(posedge clk); #1;
            if (i == 0) t0 = cyc;
            check($sformatf("ovf_after_push%0d", i), int'(ovf8), int'(i == 5));
            check($sformatf("full_after_push%0d", i), int'(full8), int'(i >= 4));
        end
        wen8 = 1'b0;
        @(posedge clk); #1;
        check("ovf_one_cycle", int'(ovf8), 0);
        for (int k = 0; k < 200; k++) begin
            if (!busy8) begin bl = cyc - t0; break; end
            @(posedge clk); #1;
        end
        check("ovf_busy_low", bl, 65);
        check("ovf_npulse", r8_cyc.size(), 5);
        for (int p = 0; p < 5; p++) begin
            if (p < r8_cyc.size()) begin
                check($sformatf("ovf_data%0d", p), int'(r8_dat[p]), 8'h30 + p);
                if (p > 0) check($sformatf("ovf_spacing%0d", p), r8_cyc[p] - r8_cyc[p-1], 13);
            end
        end
    endtask

    task automatic test_reset_pulse();
        int busy_hits;
        busy_hits = 0;
        cur_sel = 1'b0;
        clear_mon();
        rs = 1'b1; wdata = 8'h55; wen8 = 1'b1;
        @(posedge clk); #1;
        wdata = 8'h66;
        @(posedge clk); #1;
        wen8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_en_before", int'(e8), 1);
        rst_n = 1'b0; wen8 = 1'b1; wdata = 8'h77;
        @(posedge clk); #1;
        check("rst_data", int'(d8), 0);
        check("rst_ctrl", int'(c8), 0);
        check("rst_enable", int'(e8), 0);
        check("rst_busy", int'(busy8), 0);
        check("rst_full", int'(full8), 0);
        check("rst_ovf", int'(ovf8), 0);
        rst_n = 1'b1; wen8 = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_release", int'(busy8), 0);
        clear_mon();
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (busy8) busy_hits++;
        end
        check("rst_fifo_empty", busy_hits, 0);
        check("rst_no_pulse", r8_cyc.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rs = 1'b0; wdata = 8'h00; wen8 = 1'b0; wen4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_data", int'(d8), 0);
        check("init_ctrl", int'(c8), 0);
        check("init_enable", int'(e8), 0);
        check("init_busy", int'(busy8), 0);
        check("init_full", int'(full8), 0);
        check("init_ovf", int'(ovf8), 0);
        check("init_data4", int'(d4), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //         sel   rs    wdata  exp_hi exp_lo busy
        vecs[0] = '{1'b0, 1'b1, 8'h41, 8'h41, 8'h00, 13};
        vecs[1] = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 28};
        vecs[2] = '{1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 28};
        vecs[3] = '{1'b0, 1'b0, 8'h03, 8'h03, 8'h00, 28};
        vecs[4] = '{1'b0, 1'b0, 8'h04, 8'h04, 8'h00, 13};
        vecs[5] = '{1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 13};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 13};
        vecs[7] = '{1'b1, 1'b1, 8'hA5, 8'hA0, 8'h50, 20};
        vecs[8] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h10, 35};
        vecs[9] = '{1'b1, 1'b0, 8'h38, 8'h30, 8'h80, 20};

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        test_overflow();
        test_reset_pulse();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
